fnd_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment (FND) scan controller, the successor to the fixed 4-digit ring-counter selector. It time-slices N_DIGITS common-anode/cathode digits, decodes a packed hex word to segment patterns, and inserts a programmable anti-ghosting blank interval at the start of every digit slot. It also provides per-digit enable masking, leading-zero blanking, per-digit decimal points, frame-coherent input capture and a frame-start strobe. It sits between the display-value producers and the board FND pins.

---
 rtl/fnd_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
`timescale 1ns/1ps
// Multiplexed seven-segment scan controller: time-slices N_DIGITS digits with an
// anti-ghosting blank at the start of each slot, hex decode, masking and leading-zero blanking.
//
// phase    | meaning
// ST_BLANK | cnt < BLANK_CYCLES, all selects and segments off
// ST_SHOW  | cnt >= BLANK_CYCLES, digit idx driven if its captured mask bit is set
module fnd_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_digits,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_en_mask,
  input  logic                  i_lzb,
  output logic [N_DIGITS-1:0]   o_fnd_sel,
  output logic [7:0]            o_fnd_seg,
  output logic                  o_frame
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} phase_t;

  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [IW-1:0]         idx_q, idx_nxt;
  logic [4*N_DIGITS-1:0] cap_digits_q, cap_digits_nxt;
  logic [N_DIGITS-1:0]   cap_dp_q, cap_dp_nxt;
  logic [N_DIGITS-1:0]   cap_mask_q, cap_mask_nxt;
  logic                  cap_lzb_q, cap_lzb_nxt;
  logic [N_DIGITS-1:0]   sel_q, sel_nxt;
  logic [7:0]            seg_q, seg_nxt;
  logic                  frame_q, frame_nxt;
  phase_t                phase_nxt;
  logic                  load_cap;
  logic                  hi_nonzero;
  logic                  lz_blank;
  logic [3:0]            nib;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_nxt    = cnt_q + CW'(1);
    idx_nxt    = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Captures are looked ahead so a slot can show them the cycle after loading.
    load_cap       = (cnt_q == '0) && (idx_q == '0);
    cap_digits_nxt = load_cap ? i_digits  : cap_digits_q;
    cap_dp_nxt     = load_cap ? i_dp      : cap_dp_q;
    cap_mask_nxt   = load_cap ? i_en_mask : cap_mask_q;
    cap_lzb_nxt    = load_cap ? i_lzb     : cap_lzb_q;

    phase_nxt = (cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_SHOW;

    hi_nonzero = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k >= int'(idx_nxt) && cap_digits_nxt[4*k +: 4] != 4'h0) hi_nonzero = 1'b1;
    end
    lz_blank = cap_lzb_nxt && (idx_nxt != '0) && !hi_nonzero;
    nib      = cap_digits_nxt[{idx_nxt, 2'b00} +: 4];

    sel_nxt = '0;
    seg_nxt = '0;
    if (phase_nxt == ST_SHOW && cap_mask_nxt[idx_nxt]) begin
      sel_nxt[idx_nxt] = 1'b1;
      seg_nxt          = {cap_dp_nxt[idx_nxt], lz_blank ? 7'h00 : seg7(nib)};
    end

    frame_nxt = (cnt_nxt == '0) && (idx_nxt == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      cap_digits_q <= '0;
      cap_dp_q     <= '0;
      cap_mask_q   <= '0;
      cap_lzb_q    <= 1'b0;
      sel_q        <= {N_DIGITS{ACTIVE_LOW}};
      seg_q        <= {8{ACTIVE_LOW}};
      frame_q      <= 1'b1;
    end else begin
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      cap_digits_q <= cap_digits_nxt;
      cap_dp_q     <= cap_dp_nxt;
      cap_mask_q   <= cap_mask_nxt;
      cap_lzb_q    <= cap_lzb_nxt;
      sel_q        <= ACTIVE_LOW ? ~sel_nxt : sel_nxt;
      seg_q        <= ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      frame_q      <= frame_nxt;
    end
  end

  // frame_q rests at 1 in reset so the first post-release cycle strobes; reset masks it.
  assign o_frame   = frame_q & ~i_reset;
  assign o_fnd_sel = sel_q;
  assign o_fnd_seg = seg_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for fnd_scan_ctrl: a cycle-time reference model pushes expected
// outputs per cycle; a monitor compares both polarity variants of the DUT.
module tb_fnd_scan_ctrl;

  localparam int N     = 4;
  localparam int TD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * TD;

  typedef struct packed {
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        fr;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0, mask = '0;
  logic        lzb = 1'b0;
  logic [15:0] nxt_digits = '0;
  logic [3:0]  nxt_dp = '0, nxt_mask = '0;
  logic        nxt_lzb = 1'b0;

  logic [3:0]  sel_h, sel_l;
  logic [7:0]  seg_h, seg_l;
  logic        fr_h, fr_l;

  logic [15:0] cap_digits = '0;
  logic [3:0]  cap_dp = '0, cap_mask = '0;
  logic        cap_lzb = 1'b0;
  int          t = 0;
  int          n_err = 0;
  int          n_chk = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b0)) dut_h (
    .i_clk(clk), .i_reset(rst), .i_digits(digits), .i_dp(dp), .i_en_mask(mask), .i_lzb(lzb),
    .o_fnd_sel(sel_h), .o_fnd_seg(seg_h), .o_frame(fr_h));

  fnd_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b1)) dut_l (
    .i_clk(clk), .i_reset(rst), .i_digits(digits), .i_dp(dp), .i_en_mask(mask), .i_lzb(lzb),
    .o_fnd_sel(sel_l), .o_fnd_seg(seg_l), .o_frame(fr_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: cycle t since release -> slot/digit by division; captures snapshot at frame start.
  task automatic model_push();
    exp_t e;
    int   c, d;
    if (t % FRAME == 0) begin
      cap_digits = digits;
      cap_dp     = dp;
      cap_mask   = mask;
      cap_lzb    = lzb;
    end
    c     = t % TD;
    d     = (t / TD) % N;
    e.sel = '0;
    e.seg = '0;
    e.fr  = (t % FRAME == 0);
    e.t   = 32'(t);
    if (c >= BL && cap_mask[d]) begin
      e.sel[d] = 1'b1;
      e.seg[7] = cap_dp[d];
      if (!(cap_lzb && d > 0 && (cap_digits >> (4 * d)) == 16'h0))
        e.seg[6:0] = seg_tab[cap_digits[4*d +: 4]];
    end
    exp_q.push_back(e);
    t++;
  endtask

  task automatic step(input bit rnd);
    @(negedge clk);
    if (rnd && $urandom_range(0, 3) == 0) begin
      nxt_digits = 16'($urandom);
      if ($urandom_range(0, 1) == 1) nxt_digits = nxt_digits & (16'hFFFF >> (4 * $urandom_range(1, 3)));
      nxt_dp   = 4'($urandom);
      nxt_mask = 4'($urandom);
      nxt_lzb  = 1'($urandom);
    end
    digits = nxt_digits;
    dp     = nxt_dp;
    mask   = nxt_mask;
    lzb    = nxt_lzb;
    model_push();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic chk_inactive(input string name);
    chk({name, "_sel_h"}, 32'(sel_h), 32'h0);
    chk({name, "_seg_h"}, 32'(seg_h), 32'h0);
    chk({name, "_sel_l"}, 32'(sel_l), 32'hF);
    chk({name, "_seg_l"}, 32'(seg_l), 32'hFF);
    chk({name, "_frame"}, 32'({fr_h, fr_l}), 32'h0);
  endtask

  always @(negedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("scan_al0 t=%0d", mon_e.t), 32'({fr_h, sel_h, seg_h}),
          32'({mon_e.fr, mon_e.sel, mon_e.seg}));
      chk($sformatf("scan_al1 t=%0d", mon_e.t), 32'({fr_l, sel_l, seg_l}),
          32'({mon_e.fr, ~mon_e.sel, ~mon_e.seg}));
      if (mon_e.sel != 4'h0)
        chk($sformatf("onehot t=%0d", mon_e.t), 32'($onehot0(sel_h)), 32'h1);
    end
  end

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    repeat (3) @(posedge clk);
    #1;
    chk_inactive("reset_init");

    // Decode with dp on digit 2.
    nxt_digits = 16'h12AF; nxt_dp = 4'b0100; nxt_mask = 4'hF; nxt_lzb = 1'b0;
    digits = nxt_digits; dp = nxt_dp; mask = nxt_mask; lzb = nxt_lzb;
    release_reset();
    repeat (2 * FRAME) step(1'b0);

    // Leading-zero blanking.
    nxt_digits = 16'h0070; nxt_dp = 4'b0000; nxt_lzb = 1'b1;
    repeat (2 * FRAME) step(1'b0);

    // Mask plus mid-frame change that must stay invisible until the next frame.
    nxt_digits = 16'h3456; nxt_mask = 4'b1010; nxt_lzb = 1'b0;
    repeat (10) step(1'b0);
    nxt_digits = 16'h9ABC; nxt_dp = 4'hF;
    repeat (2 * FRAME - 10) step(1'b0);

    // All-zero mask: dark, but frame strobes continue.
    nxt_mask = 4'h0;
    repeat (2 * FRAME) step(1'b0);

    // Reset in the middle of digit 2's SHOW phase.
    nxt_mask = 4'hF; nxt_digits = 16'h8421; nxt_dp = 4'b0101;
    while (t % FRAME != 22) step(1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_inactive("reset_async");
    repeat (3) @(posedge clk);
    #1;
    chk_inactive("reset_hold");
    release_reset();
    repeat (2 * FRAME) step(1'b0);

    repeat (20 * FRAME) step(1'b1);

    repeat (2) @(negedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
